sm2_modred: RTL and testbench

//  Sequential reduction of a 512-bit product modulo the SM2 prime
//  p = FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF.

---
 rtl/sm2_modred_if.sv | 30 +++
 rtl/sm2_modred.sv | 205 ++++++++++++++++++++
 tb/tb_sm2_modred.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm2_modred_if.sv
// Purpose : handshake/bus bundle between a mul256 producer and sm2_modred.
// Latency : none, wires only.
// Backpressure: none; the producer watches busy/done and re-issues start edges itself.
// Signals : start (request, rising edge accepts c), c (512-bit product),
//           r (256-bit reduced result), done (one-cycle pulse), busy (operation in flight).
interface sm2_modred_if;
  logic         start;
  logic [511:0] c;
  logic [255:0] r;
  logic         done;
  logic         busy;

  // Producer side: drives the request and the operand.
  modport master (
    output start,
    output c,
    input  r,
    input  done,
    input  busy
  );

  // Reducer side: consumes the request, returns the result.
  modport slave (
    input  start,
    input  c,
    output r,
    output done,
    output busy
  );
endinterface

// File: rtl/sm2_modred.sv
// Purpose : sequential reduction of a 512-bit product modulo the SM2 prime p into [0, p-1].
// Latency : ND + nf + 2 cycles from the accepting edge to done (nf = 0..2 fold cycles);
//           fixed at ND + 4 when SM2_MODRED_CONST_TIME_EN is defined.
// Backpressure: none; a start edge arriving while an operation is in flight is dropped.
//
// Ports   : clk  - system clock, rising edge
//           rstn - asynchronous active-low reset; aborts any operation in flight
//           bus  - sm2_modred_if.slave: start/c in, r/done/busy out
// Params  : DIG_W - digit width per DIGIT cycle, 16 or 32; ND = 512 / DIG_W
// Macro   : SM2_MODRED_CONST_TIME_EN - data-independent timing (two FOLD cycles always)
//
// Reduction uses 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p): anything above bit 255 is
// folded back into the low 256 bits with shifts and adds only.
module sm2_modred #(
  parameter int DIG_W = 32
) (
  input  logic        clk,
  input  logic        rstn,
  sm2_modred_if.slave bus
);

  localparam int ND = 512 / DIG_W;
  localparam int CW = $clog2(ND);
  localparam int XW = 260 + DIG_W;

  localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [259:0] P_EXT = {4'h0,
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIGIT,
    S_FOLD,
    S_SUB,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic          start_q;
  logic [511:0]  sreg;
  logic [CW-1:0] dig_cnt;
  logic [259:0]  acc;
  logic [255:0]  r_q;
  logic          done_q;
  logic          busy_q;
`ifdef SM2_MODRED_CONST_TIME_EN
  logic          fold_cnt;
`endif

  logic          accept;
  logic          last_dig;
  logic [259:0]  acc_dig;
  logic [259:0]  acc_fold;
  logic [259:0]  acc_min_p;
  logic          acc_ge_p;

  // One fold step: split x at bit 256 into t (high) and lo, then
  // lo + t*2^224 + t*2^96 - t*2^64 + t. The t*2^224 term always dominates
  // t*2^64, so the 260-bit result never goes negative. The accumulator never
  // reaches 2^260 (the first digit only contributes DIG_W bits), so 260 bits
  // hold every intermediate without truncation.
  function automatic logic [259:0] fold(input logic [XW-1:0] x);
    logic [259:0] t;
    logic [259:0] lo;
    t  = {{(256 - DIG_W){1'b0}}, x[XW-1:256]};
    lo = {4'h0, x[255:0]};
    return lo + (t << 224) + (t << 96) - (t << 64) + t;
  endfunction

  // Only a fresh rising edge of start, and only when idle, begins an operation.
  assign accept   = bus.start & ~start_q & (state == S_IDLE);
  assign last_dig = (dig_cnt == CNT_LAST);

  // DIGIT: shift the next most-significant digit in, then fold the overflow.
  assign acc_dig   = fold({acc, sreg[511 -: DIG_W]});
  // FOLD: same step with no new digit; only acc[259:256] feeds t.
  assign acc_fold  = fold({{DIG_W{1'b0}}, acc});
  // SUB: both the difference and the compare are always formed.
  assign acc_min_p = acc - P_EXT;
  assign acc_ge_p  = (acc >= P_EXT);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = S_DIGIT;
        end
      end
      S_DIGIT: begin
        if (last_dig) begin
`ifdef SM2_MODRED_CONST_TIME_EN
          state_nx = S_FOLD;
`else
          // Skip FOLD entirely when the last digit left no overflow.
          state_nx = (acc_dig[259:256] != 4'h0) ? S_FOLD : S_SUB;
`endif
        end
      end
      S_FOLD: begin
`ifdef SM2_MODRED_CONST_TIME_EN
        // Exactly two fold cycles; a fold with t = 0 leaves acc unchanged.
        if (fold_cnt) begin
          state_nx = S_SUB;
        end
`else
        // Leave as soon as this fold clears the overflow bits (at most twice).
        if (acc_fold[259:256] == 4'h0) begin
          state_nx = S_SUB;
        end
`endif
      end
      S_SUB: begin
        state_nx = S_OUT;
      end
      S_OUT: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q  <= 1'b0;
      sreg     <= '0;
      dig_cnt  <= '0;
      acc      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SM2_MODRED_CONST_TIME_EN
      fold_cnt <= 1'b0;
`endif
    end else begin
      start_q <= bus.start;
      done_q  <= (state == S_OUT);

      // busy covers the done cycle; an accept in that same cycle keeps it high.
      if (accept) begin
        busy_q <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            sreg    <= bus.c;
            acc     <= '0;
            dig_cnt <= '0;
          end
        end
        S_DIGIT: begin
          acc      <= acc_dig;
          sreg     <= {sreg[511-DIG_W:0], {DIG_W{1'b0}}};
          dig_cnt  <= dig_cnt + CNT_ONE;
`ifdef SM2_MODRED_CONST_TIME_EN
          fold_cnt <= 1'b0;
`endif
        end
        S_FOLD: begin
          acc      <= acc_fold;
`ifdef SM2_MODRED_CONST_TIME_EN
          fold_cnt <= ~fold_cnt;
`endif
        end
        S_SUB: begin
          // acc < 2^256 < 2p here, so one conditional subtraction is enough.
          if (acc_ge_p) begin
            acc <= acc_min_p;
          end
        end
        S_OUT: begin
          // Old result stays visible until this operation's own done.
          r_q <= acc[255:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.r    = r_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_sm2_modred.sv
// Purpose : self-checking bench for sm2_modred (DIG_W = 32) against a c % p reference.
// Latency : expects 18..20 cycles accept-to-done (exactly 20 with SM2_MODRED_CONST_TIME_EN).
// Backpressure: exercises dropped start edges mid-operation and back-to-back starts.
module tb_sm2_modred;

  localparam logic [255:0] P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

`ifdef SM2_MODRED_CONST_TIME_EN
  localparam int L_MIN = 20;
  localparam int L_MAX = 20;
`else
  localparam int L_MIN = 18;
  localparam int L_MAX = 20;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  sm2_modred_if bus();

  sm2_modred #(.DIG_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the full-width value.
  function automatic logic [255:0] ref_mod(input logic [511:0] x);
    logic [511:0] m;
    m = x % {256'd0, P};
    return m[255:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v = {v[223:0], 32'($urandom())};
    end
    return v;
  endfunction

  function automatic logic [255:0] rnd_fe();
    logic [255:0] v;
    v = rnd256();
    if (v >= P) v = v - P;
    return v;
  endfunction

  // One complete operation: start edge, wait for done, check pulse shape.
  task automatic run_op(input string tag, input logic [511:0] cv,
                        output logic [255:0] rv, output int lat);
    bit seen;
    @(negedge clk);
    bus.c     = cv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_acc"}, {511'd0, bus.busy}, 512'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.c     = ~cv;          // operand must have been captured at the accept edge
    seen = 1'b0;
    lat  = -1;
    rv   = '0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        rv   = bus.r;
        check({tag, "_busy_done"}, {511'd0, bus.busy}, 512'd1);
      end
    end
    if (!seen) check({tag, "_timeout"}, 512'd0, 512'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {511'd0, bus.done}, 512'd0);
    check({tag, "_busy_idle"},  {511'd0, bus.busy}, 512'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [511:0] dir_c   [6];
    logic [255:0] dir_exp [6];
    logic [511:0] pm1;
    logic [511:0] cv;
    logic [511:0] c1;
    logic [511:0] c2;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] rv;
    logic [255:0] r1;
    int           lat;
    int           ndone;
    bit           seen;

    bus.start = 1'b0;
    bus.c     = '0;
    rstn      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r",    {256'd0, bus.r},    512'd0);
    check("rst_done", {511'd0, bus.done}, 512'd0);
    check("rst_busy", {511'd0, bus.busy}, 512'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed corner values.
    pm1 = {256'd0, P - 256'd1};
    dir_c[0] = 512'd0;                  dir_exp[0] = 256'd0;
    dir_c[1] = {256'd0, P};             dir_exp[1] = 256'd0;
    dir_c[2] = {256'd0, P} + 512'd5;    dir_exp[2] = 256'd5;
    dir_c[3] = pm1;                     dir_exp[3] = P - 256'd1;
    dir_c[4] = pm1 * pm1;               dir_exp[4] = 256'd1;
    dir_c[5] = {512{1'b1}};             dir_exp[5] = ref_mod({512{1'b1}});
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("dir%0d", i), dir_c[i], rv, lat);
      check($sformatf("dir%0d_r", i), {256'd0, rv}, {256'd0, dir_exp[i]});
      if (i == 0) begin
        check("dir0_lat", 512'(lat), 512'(L_MIN));
      end else begin
        check($sformatf("dir%0d_lat_rng", i), {511'd0, (lat >= L_MIN && lat <= L_MAX)}, 512'd1);
      end
    end

    // Random: chained mul256-style products plus raw 512-bit values.
    a = rnd_fe();
    for (int i = 0; i < 1500; i++) begin
      if ((i % 4) == 3) begin
        cv = {rnd256(), rnd256()};
      end else begin
        b  = rnd_fe();
        cv = {256'd0, a} * {256'd0, b};
      end
      run_op("rnd", cv, rv, lat);
      check("rnd_r", {256'd0, rv}, {256'd0, ref_mod(cv)});
      check("rnd_lat_rng", {511'd0, (lat >= L_MIN && lat <= L_MAX)}, 512'd1);
      a = (rv == 256'd0 || (i % 16) == 15) ? rnd_fe() : rv;
    end

    // Start edge mid-operation is dropped.
    c1 = {rnd256(), rnd256()};
    c2 = {rnd256(), rnd256()};
    @(negedge clk);
    bus.c     = c1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.c     = c2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.c     = '0;
    ndone = 0;
    rv    = '0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        rv = bus.r;
      end
    end
    check("mid_ndone", 512'(ndone), 512'd1);
    check("mid_r", {256'd0, rv}, {256'd0, ref_mod(c1)});

    // Start edge in the done cycle is accepted.
    c1 = {rnd256(), rnd256()};
    c2 = {rnd256(), rnd256()};
    @(negedge clk);
    bus.c     = c1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check("b2b_first_done", {511'd0, seen}, 512'd1);
    r1 = bus.r;
    check("b2b_r1", {256'd0, r1}, {256'd0, ref_mod(c1)});
    @(negedge clk);
    bus.c     = c2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_busy",   {511'd0, bus.busy}, 512'd1);
    check("b2b_r_hold", {256'd0, bus.r},    {256'd0, ref_mod(c1)});
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    rv  = '0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        rv  = bus.r;
      end
    end
    check("b2b_lat_rng", {511'd0, (lat >= L_MIN && lat <= L_MAX)}, 512'd1);
    check("b2b_r2", {256'd0, rv}, {256'd0, ref_mod(c2)});

    // Reset in the middle of an operation aborts it.
    c1 = {rnd256(), rnd256()};
    @(negedge clk);
    bus.c     = c1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_r",    {256'd0, bus.r},    512'd0);
    check("abort_busy", {511'd0, bus.busy}, 512'd0);
    check("abort_done", {511'd0, bus.done}, 512'd0);
    @(negedge clk);
    rstn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("abort_no_done", 512'(ndone), 512'd0);
    c2 = {rnd256(), rnd256()};
    run_op("post_rst", c2, rv, lat);
    check("post_rst_r", {256'd0, rv}, {256'd0, ref_mod(c2)});
    check("post_rst_lat_rng", {511'd0, (lat >= L_MIN && lat <= L_MAX)}, 512'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
